// File: rtl/interrupt_control_unit_if.sv
// Bus and core-handshake bundle for the interrupt control unit.
// The master side is the CPU core / bus fabric; the slave side is the ICU.
interface interrupt_control_unit_if;
  logic [15:0] data_bus_write;
  logic [15:0] data_bus_read;
  logic [31:0] data_bus_addr;
  logic [1:0]  data_bus_mode;
  logic        data_bus_select;
  logic        cpu_irq;
  logic [3:0]  cpu_irq_cause;
  logic        cpu_irq_ack;
  logic        cpu_irq_ret;

  modport master (
    output data_bus_write, data_bus_addr, data_bus_mode, data_bus_select,
    output cpu_irq_ack, cpu_irq_ret,
    input  data_bus_read, cpu_irq, cpu_irq_cause
  );

  modport slave (
    input  data_bus_write, data_bus_addr, data_bus_mode, data_bus_select,
    input  cpu_irq_ack, cpu_irq_ret,
    output data_bus_read, cpu_irq, cpu_irq_cause
  );
endinterface

// File: rtl/interrupt_control_unit.sv
// Interrupt control unit: latches active-low IRQ lines into pending flags and
// delivers the lowest-index enabled line to the core through a req/ack/ret handshake.
module interrupt_control_unit #(
  parameter int NUM_IRQS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQS-1:0] irq_in_n,
  interrupt_control_unit_if.slave bus
);

  localparam logic [31:0] ADDR_MASK    = 32'h0000_4000;
  localparam logic [31:0] ADDR_PENDING = 32'h0000_4004;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_4008;
  localparam logic [31:0] ADDR_CTRL    = 32'h0000_400C;
  localparam logic [15:0] IMPL_MASK    = (NUM_IRQS >= 16) ? 16'hFFFF
                                         : 16'((32'd1 << NUM_IRQS) - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [15:0] mask_r;
  logic [15:0] pending_r, pending_nxt_s;
  logic        ctrl_en_r;
  logic [3:0]  cause_r, cause_nxt_s;
  logic        cpu_irq_r, cpu_irq_nxt_s;

  logic        wr_en_s, rd_en_s;
  logic [15:0] irq_set_s;
  logic [15:0] w1c_s;
  logic [15:0] ack_clr_s;
  logic        ack_take_s;
  logic [15:0] candidates_s;
  logic [3:0]  sel_s;
  logic        live_s;
  logic [15:0] rd_data_s;

  function automatic logic [3:0] lowest_index(input logic [15:0] vec);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign wr_en_s      = bus.data_bus_select && (bus.data_bus_mode == 2'b10);
  assign rd_en_s      = bus.data_bus_select && (bus.data_bus_mode == 2'b01);
  assign candidates_s = pending_r & mask_r;
  assign sel_s        = lowest_index(candidates_s);
  assign live_s       = pending_r[cause_r] & mask_r[cause_r] & ctrl_en_r;

  // Zero-extend the active-low lines into a 16-bit set vector.
  always_comb begin
    irq_set_s = 16'h0000;
    for (int i = 0; i < NUM_IRQS; i++) begin
      irq_set_s[i] = ~irq_in_n[i];
    end
  end

  // Pending clear sources; the set term is ORed in last so a live line wins.
  always_comb begin
    if (wr_en_s && (bus.data_bus_addr == ADDR_PENDING)) begin
      w1c_s = bus.data_bus_write;
    end else begin
      w1c_s = 16'h0000;
    end
    if (ack_take_s) begin
      ack_clr_s = 16'h0001 << cause_r;
    end else begin
      ack_clr_s = 16'h0000;
    end
    pending_nxt_s = ((pending_r & ~(w1c_s | ack_clr_s)) | irq_set_s) & IMPL_MASK;
  end

  // Handshake FSM next-state logic.
  always_comb begin
    state_nxt_s   = state_r;
    cause_nxt_s   = cause_r;
    cpu_irq_nxt_s = 1'b0;
    ack_take_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ctrl_en_r && (candidates_s != 16'h0000)) begin
          state_nxt_s   = ST_REQUEST;
          cause_nxt_s   = sel_s;
          cpu_irq_nxt_s = 1'b1;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_REQUEST: begin
        if (bus.cpu_irq_ack) begin
          ack_take_s    = 1'b1;
          state_nxt_s   = ST_SERVICE;
        end else if (!live_s) begin
          state_nxt_s   = ST_IDLE;
        end else begin
          cpu_irq_nxt_s = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (bus.cpu_irq_ret) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SERVICE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, cause and request output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cause_r   <= 4'd0;
      cpu_irq_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cause_r   <= cause_nxt_s;
      cpu_irq_r <= cpu_irq_nxt_s;
    end
  end

  // Software-visible registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_r    <= 16'h0000;
      pending_r <= 16'h0000;
      ctrl_en_r <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      if (wr_en_s && (bus.data_bus_addr == ADDR_MASK)) begin
        mask_r <= bus.data_bus_write & IMPL_MASK;
      end
      if (wr_en_s && (bus.data_bus_addr == ADDR_CTRL)) begin
        ctrl_en_r <= bus.data_bus_write[0];
      end
    end
  end

  // Read mux; unmapped addresses read zero.
  always_comb begin
    rd_data_s = 16'h0000;
    if (rd_en_s) begin
      case (bus.data_bus_addr)
        ADDR_MASK:    rd_data_s = mask_r;
        ADDR_PENDING: rd_data_s = pending_r;
        ADDR_STATUS:  rd_data_s = {6'b000000, (state_r == ST_SERVICE),
                                   (state_r == ST_REQUEST), 4'b0000, cause_r};
        ADDR_CTRL:    rd_data_s = {15'h0000, ctrl_en_r};
        default:      rd_data_s = 16'h0000;
      endcase
    end else begin
      rd_data_s = 16'h0000;
    end
  end

  assign bus.data_bus_read  = rd_data_s;
  assign bus.cpu_irq        = cpu_irq_r;
  assign bus.cpu_irq_cause  = cause_r;

endmodule

// File: tb/tb_interrupt_control_unit.sv
// Directed bench for interrupt_control_unit: hand-computed expectations,
// inputs driven 1 time unit after the rising edge and sampled there.
module tb_interrupt_control_unit;
  logic       clk;
  logic       reset;
  logic [7:0] irq_in_n;
  int         num_compared;
  int         num_mismatched;

  interrupt_control_unit_if bus_if();

  interrupt_control_unit #(.NUM_IRQS(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_in_n (irq_in_n),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_compared++;
    if (obs !== exp) begin
      num_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [15:0] data);
    bus_if.data_bus_select = 1'b1;
    bus_if.data_bus_mode   = 2'b10;
    bus_if.data_bus_addr   = addr;
    bus_if.data_bus_write  = data;
    tick();
    bus_if.data_bus_select = 1'b0;
    bus_if.data_bus_mode   = 2'b00;
    bus_if.data_bus_write  = 16'h0000;
  endtask

  task automatic bus_rd_chk(input string tag, input logic [31:0] addr, input logic [15:0] exp);
    bus_if.data_bus_select = 1'b1;
    bus_if.data_bus_mode   = 2'b01;
    bus_if.data_bus_addr   = addr;
    #1;
    check_eq(tag, {16'h0000, bus_if.data_bus_read}, {16'h0000, exp});
    bus_if.data_bus_select = 1'b0;
    bus_if.data_bus_mode   = 2'b00;
  endtask

  task automatic pulse_irq(input logic [7:0] lines);
    irq_in_n = ~lines;
    tick();
    irq_in_n = 8'hFF;
  endtask

  task automatic pulse_ack();
    bus_if.cpu_irq_ack = 1'b1;
    tick();
    bus_if.cpu_irq_ack = 1'b0;
  endtask

  task automatic pulse_ret();
    bus_if.cpu_irq_ret = 1'b1;
    tick();
    bus_if.cpu_irq_ret = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp_irq, input logic [3:0] exp_cause);
    check_eq({tag, "_irq"}, {31'd0, bus_if.cpu_irq}, {31'd0, exp_irq});
    if (exp_irq) begin
      check_eq({tag, "_cause"}, {28'd0, bus_if.cpu_irq_cause}, {28'd0, exp_cause});
    end
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    clk      = 1'b0;
    reset    = 1'b1;
    irq_in_n = 8'hFF;
    bus_if.data_bus_write  = 16'h0000;
    bus_if.data_bus_addr   = 32'h0000_0000;
    bus_if.data_bus_mode   = 2'b00;
    bus_if.data_bus_select = 1'b0;
    bus_if.cpu_irq_ack     = 1'b0;
    bus_if.cpu_irq_ret     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check_eq("rst_irq", {31'd0, bus_if.cpu_irq}, 32'd0);
    check_eq("rst_cause", {28'd0, bus_if.cpu_irq_cause}, 32'd0);
    bus_rd_chk("rst_status", 32'h4008, 16'h0000);
    bus_rd_chk("rst_pending", 32'h4004, 16'h0000);

    // 1: single request, ack, return
    bus_wr(32'h4000, 16'h0004);
    bus_wr(32'h400C, 16'h0001);
    pulse_irq(8'h04);
    bus_rd_chk("t1_pending", 32'h4004, 16'h0004);
    check_eq("t1_irq_not_yet", {31'd0, bus_if.cpu_irq}, 32'd0);
    tick();
    chk_irq("t1_req", 1'b1, 4'd2);
    pulse_ack();
    bus_rd_chk("t1_pend_acked", 32'h4004, 16'h0000);
    bus_rd_chk("t1_status_srv", 32'h4008, 16'h0202);
    chk_irq("t1_srv", 1'b0, 4'd0);
    pulse_ret();
    bus_rd_chk("t1_status_idle", 32'h4008, 16'h0002);
    tick();
    chk_irq("t1_after_ret", 1'b0, 4'd0);

    // 2: priority and back-to-back latency
    bus_wr(32'h4000, 16'h00FF);
    pulse_irq(8'h22);
    bus_rd_chk("t2_pending", 32'h4004, 16'h0022);
    tick();
    chk_irq("t2_first", 1'b1, 4'd1);
    pulse_ack();
    bus_rd_chk("t2_pend_left", 32'h4004, 16'h0020);
    pulse_ret();
    chk_irq("t2_ret_gap", 1'b0, 4'd0);
    tick();
    chk_irq("t2_second", 1'b1, 4'd5);
    pulse_ack();
    pulse_ret();

    // 3: withdraw on mask, then reissue
    pulse_irq(8'h08);
    tick();
    chk_irq("t3_req", 1'b1, 4'd3);
    bus_wr(32'h4000, 16'h0000);
    chk_irq("t3_mask_edge", 1'b1, 4'd3);
    tick();
    chk_irq("t3_withdrawn", 1'b0, 4'd0);
    bus_rd_chk("t3_status", 32'h4008, 16'h0003);
    bus_rd_chk("t3_pending", 32'h4004, 16'h0008);
    bus_wr(32'h4000, 16'h00FF);
    chk_irq("t3_unmask_edge", 1'b0, 4'd0);
    tick();
    chk_irq("t3_reissue", 1'b1, 4'd3);
    pulse_ack();
    pulse_ret();

    // 4: global disable, set-wins-over-W1C, unimplemented bits
    bus_wr(32'h400C, 16'h0000);
    pulse_irq(8'h10);
    tick();
    tick();
    chk_irq("t4_disabled", 1'b0, 4'd0);
    bus_rd_chk("t4_pending", 32'h4004, 16'h0010);
    irq_in_n = 8'hEF;
    bus_wr(32'h4004, 16'h0010);
    bus_rd_chk("t4_set_wins", 32'h4004, 16'h0010);
    irq_in_n = 8'hFF;
    bus_wr(32'h4004, 16'h0010);
    bus_rd_chk("t4_w1c", 32'h4004, 16'h0000);
    bus_wr(32'h4000, 16'hFFFF);
    bus_rd_chk("t4_mask_hi", 32'h4000, 16'h00FF);
    bus_wr(32'h400C, 16'hFFFF);
    bus_rd_chk("t4_ctrl", 32'h400C, 16'h0001);

    // 5: no nesting, redelivery, stray pulses
    pulse_irq(8'h01);
    tick();
    chk_irq("t5_req", 1'b1, 4'd0);
    pulse_ack();
    pulse_irq(8'h01);
    pulse_ack();
    tick();
    chk_irq("t5_no_nest", 1'b0, 4'd0);
    bus_rd_chk("t5_status_srv", 32'h4008, 16'h0200);
    bus_rd_chk("t5_pending", 32'h4004, 16'h0001);
    pulse_ret();
    chk_irq("t5_ret_gap", 1'b0, 4'd0);
    tick();
    chk_irq("t5_redeliver", 1'b1, 4'd0);
    pulse_ret();
    chk_irq("t5_stray_ret", 1'b1, 4'd0);
    bus_rd_chk("t5_status_req", 32'h4008, 16'h0100);
    pulse_ack();
    pulse_ret();
    pulse_ack();
    chk_irq("t5_stray_ack", 1'b0, 4'd0);
    bus_rd_chk("t5_status_idle", 32'h4008, 16'h0000);
    bus_rd_chk("t5_pend_clear", 32'h4004, 16'h0000);

    // 6: async reset mid-request, unmapped reads
    pulse_irq(8'h40);
    tick();
    chk_irq("t6_req", 1'b1, 4'd6);
    bus_rd_chk("t6_unmapped_live", 32'h4030, 16'h0000);
    reset = 1'b1;
    #1;
    check_eq("t6_rst_irq", {31'd0, bus_if.cpu_irq}, 32'd0);
    check_eq("t6_rst_cause", {28'd0, bus_if.cpu_irq_cause}, 32'd0);
    bus_rd_chk("t6_rst_mask", 32'h4000, 16'h0000);
    bus_rd_chk("t6_rst_pending", 32'h4004, 16'h0000);
    bus_rd_chk("t6_rst_status", 32'h4008, 16'h0000);
    bus_rd_chk("t6_rst_ctrl", 32'h400C, 16'h0000);
    tick();
    reset = 1'b0;
    tick();
    bus_rd_chk("t6_unmapped", 32'h4030, 16'h0000);
    chk_irq("t6_idle", 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end
endmodule
